// File: rtl/pc_fetch_if.sv
// pc_fetch_if: decode-to-fetch redirect/RAS request bundle and fetch-stage status
interface pc_fetch_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  logic             stall_f, exc_req, branch_d, jump_d, call_d, ret_d;
  logic [WIDTH-1:0] branch_target_d, jump_target_d, ret_addr_d, jr_target_d;
  logic [WIDTH-1:0] pcf, pc_plus4_f, pc_next;
  logic             fetch_valid, align_fault, ras_empty, ras_full;
  logic [CW-1:0]    ras_count;
  modport master (
    output stall_f, exc_req, branch_d, jump_d, call_d, ret_d,
    output branch_target_d, jump_target_d, ret_addr_d, jr_target_d,
    input  pcf, pc_plus4_f, pc_next, fetch_valid, align_fault, ras_empty, ras_full, ras_count
  );
  modport slave (
    input  stall_f, exc_req, branch_d, jump_d, call_d, ret_d,
    input  branch_target_d, jump_target_d, ret_addr_d, jr_target_d,
    output pcf, pc_plus4_f, pc_next, fetch_valid, align_fault, ras_empty, ras_full, ras_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC register with priority redirect, alignment check and circular RAS
module pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int               RAS_DEPTH    = 8
) (
  input logic       clk,
  input logic       reset,
  pc_fetch_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] pcf_q, pcf_d, pc_plus4, raw, top;
  logic             valid_q;
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             empty, full, upd, ras_op, push, pop, repl;
  always_comb begin
    empty    = cnt_q == '0;
    full     = cnt_q == CW'(RAS_DEPTH);
    top_idx  = ptr_q - PW'(1);
    top      = ras_q[top_idx];
    pc_plus4 = pcf_q + WIDTH'(4);
    raw      = bus.exc_req  ? EXC_VECTOR :
               bus.branch_d ? bus.branch_target_d :
               bus.jump_d   ? bus.jump_target_d :
               bus.ret_d    ? (empty ? bus.jr_target_d : top) : pc_plus4;
    upd      = bus.exc_req | !bus.stall_f;
    ras_op   = upd & !bus.exc_req & !bus.branch_d;
    // call+ret on an empty stack degenerates into a plain push
    push     = ras_op & bus.call_d & (!bus.ret_d | empty);
    pop      = ras_op & bus.ret_d & !bus.call_d & !empty;
    repl     = ras_op & bus.call_d & bus.ret_d & !empty;
    ptr_d    = push ? ptr_q + PW'(1) : pop ? top_idx : ptr_q;
    cnt_d    = (push & !full) ? cnt_q + CW'(1) : pop ? cnt_q - CW'(1) : cnt_q;
    pcf_d    = upd ? {raw[WIDTH-1:2], 2'b00} : pcf_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf_q   <= RESET_VECTOR;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pcf_q   <= pcf_d;
      valid_q <= valid_q | upd;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= bus.ret_addr_d;
    else if (repl) ras_q[top_idx] <= bus.ret_addr_d;
  end
  assign bus.pcf         = pcf_q;
  assign bus.pc_plus4_f  = pc_plus4;
  assign bus.pc_next     = {raw[WIDTH-1:2], 2'b00};
  assign bus.fetch_valid = valid_q;
  assign bus.align_fault = !bus.exc_req & (bus.branch_d | bus.jump_d | bus.ret_d) & (|raw[1:0]);
  assign bus.ras_count   = cnt_q;
  assign bus.ras_empty   = empty;
  assign bus.ras_full    = full;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, corner sequences and random traffic against a queue-based model
module tb_pc_fetch_unit;
  localparam int          W  = 32;
  localparam int          D  = 8;
  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] EV = 32'h180;
  logic clk = 0;
  logic reset = 0;
  pc_fetch_if #(.WIDTH(W), .RAS_DEPTH(D)) bus ();
  pc_fetch_unit #(.WIDTH(W), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras[$];
  typedef struct {
    bit          chk;
    logic        stall, exc, br, j, call, ret;
    logic [31:0] bt, jt, ra, jr, exp_pc;
    int          exp_cnt;
    logic        exp_af;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t nv();
    vec_t r;
    r = '{chk: 0, stall: 0, exc: 0, br: 0, j: 0, call: 0, ret: 0,
          bt: 0, jt: 0, ra: 0, jr: 0, exp_pc: 0, exp_cnt: 0, exp_af: 0};
    return r;
  endfunction

  function automatic vec_t t(logic stall, logic exc, logic br, logic [31:0] bt, logic j, logic [31:0] jt,
                             logic call, logic [31:0] ra, logic ret, logic [31:0] jr,
                             logic [31:0] epc, int ecnt, logic eaf);
    vec_t r;
    r = '{chk: 1, stall: stall, exc: exc, br: br, j: j, call: call, ret: ret,
          bt: bt, jt: jt, ra: ra, jr: jr, exp_pc: epc, exp_cnt: ecnt, exp_af: eaf};
    return r;
  endfunction

  function automatic logic [31:0] m_target(vec_t r);
    if (r.exc) return EV;
    if (r.br)  return r.bt;
    if (r.j)   return r.jt;
    if (r.ret) return m_ras.size() != 0 ? m_ras[m_ras.size()-1] : r.jr;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = RV;
    m_valid = 0;
    m_ras.delete();
  endtask

  task automatic check_state();
    check("pcf", bus.pcf, m_pc);
    check("fetch_valid", bus.fetch_valid, m_valid);
    check("ras_count", bus.ras_count, m_ras.size());
    check("ras_empty", bus.ras_empty, m_ras.size() == 0);
    check("ras_full", bus.ras_full, m_ras.size() == D);
  endtask

  task automatic apply(input vec_t r);
    logic [31:0] tgt;
    logic af;
    @(negedge clk);
    bus.stall_f = r.stall; bus.exc_req = r.exc; bus.branch_d = r.br; bus.jump_d = r.j;
    bus.call_d = r.call; bus.ret_d = r.ret; bus.branch_target_d = r.bt; bus.jump_target_d = r.jt;
    bus.ret_addr_d = r.ra; bus.jr_target_d = r.jr;
    #1;
    tgt = m_target(r);
    af = !r.exc && (r.br || r.j || r.ret) && tgt[1:0] != 2'b00;
    check("pc_next", bus.pc_next, tgt & ~32'h3);
    check("pc_plus4_f", bus.pc_plus4_f, m_pc + 32'd4);
    check("align_fault", bus.align_fault, af);
    if (r.chk) check("tbl_align_fault", bus.align_fault, r.exp_af);
    @(posedge clk);
    if (r.exc || !r.stall) begin
      m_pc = tgt & ~32'h3;
      m_valid = 1;
      if (!r.exc && !r.br) begin
        if (r.call && r.ret && m_ras.size() != 0) m_ras[m_ras.size()-1] = r.ra;
        else if (r.call) begin
          m_ras.push_back(r.ra);
          if (m_ras.size() > D) void'(m_ras.pop_front());
        end else if (r.ret && m_ras.size() != 0) void'(m_ras.pop_back());
      end
    end
    #1;
    check_state();
    if (r.chk) begin
      check("tbl_pcf", bus.pcf, r.exp_pc);
      check("tbl_ras_count", bus.ras_count, r.exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;
    bus.stall_f = 0; bus.exc_req = 0; bus.branch_d = 0; bus.jump_d = 0; bus.call_d = 0; bus.ret_d = 0;
    bus.branch_target_d = 0; bus.jump_target_d = 0; bus.ret_addr_d = 0; bus.jr_target_d = 0;
    //   stall exc br bt        j  jt         call ra          ret jr          exp_pc        cnt af
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        0, 0,        32'h04,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        0, 0,        32'h08,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        0, 0,        32'h0C,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        0, 0,        32'h10,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        0, 0,        32'h14,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        1, 32'h10,   0, 0,        32'h18,  1, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        1, 32'h20,   0, 0,        32'h1C,  2, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        1, 32'h30,   0, 0,        32'h20,  3, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'h30,  2, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'h20,  1, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'h10,  0, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'hBAC, 0, 1));
    tbl.push_back(t(1, 0, 1, 32'h100, 0, 0,        0, 0,        0, 0,        32'hBAC, 0, 0));
    tbl.push_back(t(1, 0, 1, 32'h100, 0, 0,        1, 32'h44,   0, 0,        32'hBAC, 0, 0));
    tbl.push_back(t(1, 0, 1, 32'h100, 0, 0,        0, 0,        0, 0,        32'hBAC, 0, 0));
    tbl.push_back(t(0, 0, 1, 32'h100, 0, 0,        0, 0,        0, 0,        32'h100, 0, 0));
    tbl.push_back(t(0, 0, 1, 32'h102, 0, 0,        0, 0,        0, 0,        32'h100, 0, 1));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        1, 32'h50,   0, 0,        32'h104, 1, 0));
    tbl.push_back(t(1, 1, 1, 32'h100, 0, 0,        1, 32'h60,   0, 0,        32'h180, 1, 0));
    tbl.push_back(t(0, 0, 0, 0,       1, 32'h200,  1, 32'h204,  0, 0,        32'h200, 2, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        1, 32'h300,  1, 32'hBAD,  32'h204, 2, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'h300, 1, 0));
    tbl.push_back(t(0, 0, 0, 0,       0, 0,        0, 0,        1, 32'hBAD,  32'h50,  0, 0));

    model_reset();
    #12;
    check("rst_pcf", bus.pcf, RV);
    check("rst_fetch_valid", bus.fetch_valid, 1'b0);
    check("rst_ras_count", bus.ras_count, 0);
    @(posedge clk);
    #1 reset = 1;
    check("pre_edge_fetch_valid", bus.fetch_valid, 1'b0);
    foreach (tbl[i]) apply(tbl[i]);

    // overflow: nine pushes keep the newest eight, 0x4 is lost
    for (int i = 0; i < 9; i++) begin
      r = nv(); r.call = 1; r.ra = 32'(4 * (i + 1));
      apply(r);
    end
    check("ovf_full", bus.ras_full, 1'b1);
    check("ovf_count", bus.ras_count, 8);
    for (int i = 0; i < 9; i++) begin
      r = nv(); r.ret = 1; r.jr = 32'h400;
      apply(r);
      check("ovf_pop_pcf", bus.pcf, i < 8 ? 32'(32'h24 - 4 * i) : 32'h400);
    end
    check("ovf_empty", bus.ras_empty, 1'b1);

    // wrap of the sequential path at the top of the address space
    r = nv(); r.j = 1; r.jt = 32'hFFFF_FFFC;
    apply(r);
    #1 check("wrap_plus4", bus.pc_plus4_f, 32'h0);
    apply(nv());
    check("wrap_pcf", bus.pcf, 32'h0);

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) begin
      r = nv(); r.call = 1; r.ra = 32'(32'h800 + 4 * i);
      apply(r);
    end
    @(negedge clk);
    #2 reset = 0;
    #1;
    check("async_rst_pcf", bus.pcf, RV);
    check("async_rst_valid", bus.fetch_valid, 1'b0);
    check("async_rst_count", bus.ras_count, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1;

    for (int i = 0; i < 400; i++) begin
      r = nv();
      r.stall = $urandom_range(0, 3) == 0;
      r.exc   = $urandom_range(0, 19) == 0;
      r.br    = $urandom_range(0, 6) == 0;
      r.j     = $urandom_range(0, 9) == 0;
      r.call  = $urandom_range(0, 3) == 0;
      r.ret   = $urandom_range(0, 4) == 0;
      r.bt    = {$urandom_range(0, 255), 2'(($urandom_range(0, 3) == 0) ? $urandom : 0)} ;
      r.jt    = $urandom & 32'hFFFF_FFFC;
      r.ra    = {$urandom_range(0, 1023), 2'b00};
      r.jr    = $urandom;
      apply(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised next-generation fetch-stage program counter for the 5-stage pipeline.
- Holds PCF and selects the next PC by fixed priority: exception, branch, jump, return, sequential.
- Stall is a true hold of PCF.
- Adds an exception vector, PC alignment checking, and a circular return-address stack (RAS) that predicts return targets.

Parameters:
- WIDTH, 32, PC and address width in bits (>=8).
- RESET_VECTOR, 0, PCF value after reset.
- EXC_VECTOR, 32'h0000_0180, exception handler address.
- RAS_DEPTH, 8, RAS entries; power of 2, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall_f  input  1  hold PCF and RAS this cycle.
- exc_req  input  1  redirect to EXC_VECTOR; overrides stall_f.
- branch_d  input  1  taken branch resolved in decode.
- branch_target_d  input  WIDTH  branch target.
- jump_d  input  1  direct jump (j/jal).
- jump_target_d  input  WIDTH  jump target.
- call_d  input  1  instruction in decode is a call (jal/jalr); push ret_addr_d.
- ret_addr_d  input  WIDTH  return address to push.
- ret_d  input  1  instruction in decode is a return (jr $ra).
- jr_target_d  input  WIDTH  register target, used when RAS is empty.
- pcf  output  WIDTH  current fetch PC.
- pc_plus4_f  output  WIDTH  pcf+4 modulo 2^WIDTH.
- pc_next  output  WIDTH  combinational next PC.
- fetch_valid  output  1  pcf holds a valid fetch address.
- align_fault  output  1  selected target had nonzero bits [1:0].
- ras_count  output  clog2(RAS_DEPTH)+1  live RAS entries.
- ras_empty  output  1  ras_count==0.
- ras_full  output  1  ras_count==RAS_DEPTH.

Behaviour:
- Reset (reset==0, asynchronous):
  - pcf=RESET_VECTOR, fetch_valid=0.
  - RAS pointer=0, ras_count=0, RAS contents don't-care.
  - Reset asserted mid-operation discards all state immediately.
- pc_next priority, combinational:
  - exc_req -> EXC_VECTOR
  - else branch_d -> branch_target_d
  - else jump_d -> jump_target_d
  - else ret_d -> RAS top if !ras_empty, otherwise jr_target_d
  - else pc_plus4_f
- Alignment:
  - pc_next[1:0] is forced to 00.
  - align_fault=1 when the selected redirect target had nonzero [1:0].
  - align_fault is never raised for sequential or EXC_VECTOR selections.
- Update enable: upd = exc_req | !stall_f.
  - On a rising edge with upd=1: pcf<=pc_next, fetch_valid<=1.
  - With upd=0: pcf and RAS hold.
  - fetch_valid is 0 only from reset until the first update edge.
- pc_plus4_f wraps: all-ones minus 3 -> 0.
- RAS:
  - Circular buffer; top = entry at ptr-1.
  - Operations occur only on upd edges, and only when neither exc_req nor branch_d is asserted; jumps still push.
  - Push (call_d && !ret_d): write ret_addr_d at ptr; ptr++ mod RAS_DEPTH; count saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten.
  - Pop (ret_d && !call_d): if count>0, ptr--, count--. If empty, no state change.
  - Both call_d and ret_d: replace top with ret_addr_d; count and ptr unchanged. If empty, behave as push.
  - exc_req does not flush the RAS.
- Latency:
  - A redirect asserted in cycle N appears on pcf in cycle N+1 (one edge), unless stalled.
  - Redirect inputs asserted while stall_f=1 and exc_req=0 are ignored that cycle; decode re-presents them.

Test Plan:
1. Reset release, no stall, 4 edges -> pcf = RESET_VECTOR, then +4, +8, +12, +16; fetch_valid 0 before the first edge, 1 after.
2. stall_f=1 for 3 cycles at pcf=0x40 with branch_d=1, target 0x100 -> pcf holds 0x40, no RAS change. Stall released with branch held -> pcf=0x100 next edge.
3. exc_req with stall_f=1 and branch_d=1 -> pcf=EXC_VECTOR next edge; ras_count unchanged.
4. Push 0x10, 0x20, 0x30, then ret_d three times with jr_target_d=0xBAD -> pcf sequence 0x30, 0x20, 0x10. A fourth ret_d -> 0xBAD with ras_count staying 0.
5. RAS_DEPTH=8: push 9 values 0x4..0x24 -> ras_full=1, count=8. Nine pops return 0x24..0x8, then jr_target_d; 0x4 is lost.
6. branch_target_d=0x102 -> pcf=0x100, align_fault=1 that cycle. pcf=0xFFFFFFFC sequential -> pc_plus4_f=0, pcf wraps to 0.
